// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Pipelined instruction prefetch engine. Keeps its own fetch PC, issues up to
// MAX_OUTST in-order requests to instruction memory over req/rdy/valid, and
// buffers the returned words together with their PCs in a DEPTH-entry queue
// that feeds decode. A taken branch/jump redirects fetch, flushes the queue
// and discards responses that were already in flight.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   brjmp_taken   redirect request from execute
//   brjmp_target  redirect address (bits [1:0] forced to 0)
//   dec_ready     decode consumes the head instruction this cycle
//   imem_req      request to instruction memory
//   imem_addr     request address (the fetch PC)
//   imem_rdy      memory accepts the request this cycle
//   imem_valid    response word valid this cycle (in order)
//   imem_rdata    response word
//   ir            head instruction of the queue
//   ir_pc         PC of the head instruction
//   ir_valid      queue not empty
//   stall         no instruction available (!ir_valid)

module fetch_queue_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              brjmp_taken,
    input  logic [ADDR_W-1:0] brjmp_target,
    input  logic              dec_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              stall
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [OCC_W-1:0]  occupancy;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  drop_cnt;

    logic [31:0]       credit_used;
    logic [ADDR_W-1:0] target_aligned;
    logic              accept;
    logic              resp;
    logic              push;
    logic              pop;

    // Request/credit logic. Credits count queue entries plus live (non-stale)
    // requests in flight, so every kept response is guaranteed a free slot.
    // A response seen with nothing outstanding belongs to a transaction
    // abandoned by reset and is ignored.
    always_comb begin
        target_aligned = {brjmp_target[ADDR_W-1:2], 2'b00};
        credit_used    = 32'(occupancy) + 32'(outstanding) - 32'(drop_cnt);
        imem_req       = rst && !brjmp_taken
                         && (32'(outstanding) < 32'(MAX_OUTST))
                         && (credit_used < 32'(DEPTH));
        accept         = imem_req && imem_rdy;
        resp           = imem_valid && (outstanding != '0);
        push           = resp && (drop_cnt == '0) && !brjmp_taken;
        pop            = ir_valid && dec_ready && !brjmp_taken;
        imem_addr      = fetch_pc;
        ir_valid       = (occupancy != '0);
        stall          = !ir_valid;
        ir             = q_data[head];
        ir_pc          = q_pc[head];
    end

    // Fetch and response PC tracking plus the in-flight counters. On a
    // redirect every request still outstanding becomes stale, so the drop
    // count is simply what remains outstanding after this cycle's response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (brjmp_taken) begin
                fetch_pc <= target_aligned;
                resp_pc  <= target_aligned;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_STEP;
                if (push)   resp_pc  <= resp_pc + PC_STEP;
            end

            case ({accept, resp})
                2'b10:   outstanding <= outstanding + OUT_ONE;
                2'b01:   outstanding <= outstanding - OUT_ONE;
                default: outstanding <= outstanding;
            endcase

            if (brjmp_taken)
                drop_cnt <= resp ? (outstanding - OUT_ONE) : outstanding;
            else if (resp && (drop_cnt != '0))
                drop_cnt <= drop_cnt - OUT_ONE;
        end
    end

    // Instruction queue storage. A redirect empties the queue and rewinds
    // both pointers; any pop or push in that cycle is suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (brjmp_taken) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                q_data[tail] <= imem_rdata;
                q_pc[tail]   <= resp_pc;
                tail         <= tail + PTR_ONE;
            end
            if (pop) head <= head + PTR_ONE;

            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // The credit scheme must never let a kept response arrive at a full queue.
    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (occupancy == OCC_W'(DEPTH))));

endmodule
